uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_rx_maj_sampler.sv | 39 +++
 rtl/uart_rx_param.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the parameterised UART receiver.
// State encoding, prescale floor and majority-sample offsets.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int MIN_PRESCALE = 4;
  localparam int MAJ_OFF_PRE  = 1;
  localparam int MAJ_OFF_POST = 1;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_maj_sampler.sv
// Captures the two early mid-bit samples and votes 2-of-3
// with the live sample on the decision edge.
module uart_rx_maj_sampler
  import uart_rx_pkg::*;
#(
  parameter int PS_W = 6
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            rx_s,
  input  logic            active,
  input  logic [PS_W-1:0] edge_cnt,
  input  logic [PS_W-1:0] half,
  output logic            decide,
  output logic            bit_val
);

  logic            s_lo;
  logic            s_mid;
  logic [PS_W-1:0] t_lo;
  logic [PS_W-1:0] t_hi;

  assign t_lo = half - PS_W'(MAJ_OFF_PRE);
  assign t_hi = half + PS_W'(MAJ_OFF_POST);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s_lo  <= 1'b1;
      s_mid <= 1'b1;
    end else if (active) begin
      if (edge_cnt == t_lo) s_lo <= rx_s;
      if (edge_cnt == half) s_mid <= rx_s;
    end
  end

  assign decide  = active && (edge_cnt == t_hi);
  assign bit_val = maj3(s_lo, s_mid, rx_s);

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: sync, oversampled framing,
// parity/stop/break checks and a valid/ready output register.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PS_W   = 6
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic              STOP2,
  input  logic [PS_W-1:0]   prescale,
  input  logic              DATA_RDY,
  output logic [DATA_W-1:0] P_DATA,
  output logic              DATA_VLD,
  output logic              STR_ERR,
  output logic              PAR_ERR,
  output logic              STP_ERR,
  output logic              OVR_ERR,
  output logic              BRK_DET
);

  localparam int BC_W = 4;

  logic rx_meta;
  logic rx_s;
  logic [1:0] fill;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      fill    <= 2'b00;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
      fill    <= {fill[0], 1'b1};
    end
  end

  logic [PS_W-1:0] ps_even;
  logic [PS_W-1:0] ps_eff;

  assign ps_even = prescale & ~PS_W'(1);
  assign ps_eff  = (ps_even < PS_W'(MIN_PRESCALE))
                 ? PS_W'(MIN_PRESCALE) : ps_even;

  state_t            state;
  logic [PS_W-1:0]   edge_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [PS_W-1:0]   p_lat;
  logic              par_en_l;
  logic              par_typ_l;
  logic              stop2_l;
  logic              par_bad;
  logic              stp_bad;
  logic              brk_flag;
  logic              armed;

  logic [PS_W-1:0] half;
  logic            wrap;
  logic            decide;
  logic            bit_val;
  logic            last_stop;
  logic            stp_now;
  logic            brk_now;

  assign half      = p_lat >> 1;
  assign wrap      = (edge_cnt == p_lat - PS_W'(1));
  assign last_stop = (bit_cnt == BC_W'(stop2_l));
  assign stp_now   = stp_bad | ~bit_val;
  assign brk_now   = brk_flag | (~bit_val && shreg == '0);

  uart_rx_maj_sampler #(.PS_W(PS_W)) u_maj (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .rx_s     (rx_s),
    .active   (state != S_IDLE),
    .edge_cnt (edge_cnt),
    .half     (half),
    .decide   (decide),
    .bit_val  (bit_val)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= S_IDLE;
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      p_lat     <= PS_W'(MIN_PRESCALE);
      par_en_l  <= 1'b0;
      par_typ_l <= 1'b0;
      stop2_l   <= 1'b0;
      par_bad   <= 1'b0;
      stp_bad   <= 1'b0;
      brk_flag  <= 1'b0;
      armed     <= 1'b0;
      P_DATA    <= '0;
      DATA_VLD  <= 1'b0;
      STR_ERR   <= 1'b0;
      PAR_ERR   <= 1'b0;
      STP_ERR   <= 1'b0;
      OVR_ERR   <= 1'b0;
      BRK_DET   <= 1'b0;
    end else begin
      STR_ERR <= 1'b0;
      PAR_ERR <= 1'b0;
      STP_ERR <= 1'b0;
      OVR_ERR <= 1'b0;
      BRK_DET <= 1'b0;
      if (DATA_VLD && DATA_RDY) DATA_VLD <= 1'b0;
      if (state != S_IDLE)
        edge_cnt <= wrap ? '0 : edge_cnt + PS_W'(1);
      // only a high line after reset or a break re-arms start detection
      if (state == S_IDLE && fill[1] && rx_s) armed <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (armed && !rx_s) begin
            state     <= S_START;
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            p_lat     <= ps_eff;
            par_en_l  <= PAR_EN;
            par_typ_l <= PAR_TYP;
            stop2_l   <= STOP2;
            par_bad   <= 1'b0;
            stp_bad   <= 1'b0;
            brk_flag  <= 1'b0;
          end
        end
        S_START: begin
          if (decide && bit_val) begin
            STR_ERR <= 1'b1;
            state   <= S_IDLE;
          end else if (wrap) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (decide) shreg <= {bit_val, shreg[DATA_W-1:1]};
          if (wrap) begin
            if (bit_cnt == BC_W'(DATA_W - 1)) begin
              bit_cnt <= '0;
              state   <= par_en_l ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + BC_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (decide)
            par_bad <= ((^shreg) ^ bit_val) != par_typ_l;
          if (wrap) state <= S_STOP;
        end
        S_STOP: begin
          if (decide && last_stop) begin
            state <= S_IDLE;
            armed <= bit_val;
            if (par_bad || stp_now) begin
              PAR_ERR <= par_bad;
              STP_ERR <= stp_now;
              BRK_DET <= stp_now && brk_now;
            end else if (!DATA_VLD || DATA_RDY) begin
              P_DATA   <= shreg;
              DATA_VLD <= 1'b1;
            end else begin
              OVR_ERR <= 1'b1;
            end
          end else begin
            if (decide) begin
              stp_bad  <= stp_now;
              brk_flag <= brk_now;
            end
            if (wrap) bit_cnt <= bit_cnt + BC_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8-bit and 7-bit instances
// driven with hand-built frames and checked against known words.
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rx8, pen8, ptyp8, stop2_8, rdy8;
  logic [5:0] ps8;
  logic       rx7, pen7, ptyp7, stop2_7, rdy7;
  logic [5:0] ps7;

  logic [7:0] P_DATA8;
  logic       vld8, str_e8, par_e8, stp_e8, ovr_e8, brk_d8;
  logic [6:0] P_DATA7;
  logic       vld7, str_e7, par_e7, stp_e7, ovr_e7, brk_d7;

  uart_rx_param #(.DATA_W(8), .PS_W(6)) u8 (
    .CLK(clk), .RSTn(rst_n), .RX_IN(rx8),
    .PAR_EN(pen8), .PAR_TYP(ptyp8), .STOP2(stop2_8),
    .prescale(ps8), .DATA_RDY(rdy8),
    .P_DATA(P_DATA8), .DATA_VLD(vld8),
    .STR_ERR(str_e8), .PAR_ERR(par_e8), .STP_ERR(stp_e8),
    .OVR_ERR(ovr_e8), .BRK_DET(brk_d8)
  );

  uart_rx_param #(.DATA_W(7), .PS_W(6)) u7 (
    .CLK(clk), .RSTn(rst_n), .RX_IN(rx7),
    .PAR_EN(pen7), .PAR_TYP(ptyp7), .STOP2(stop2_7),
    .prescale(ps7), .DATA_RDY(rdy7),
    .P_DATA(P_DATA7), .DATA_VLD(vld7),
    .STR_ERR(str_e7), .PAR_ERR(par_e7), .STP_ERR(stp_e7),
    .OVR_ERR(ovr_e7), .BRK_DET(brk_d7)
  );

  int n_chk = 0;
  int n_fail = 0;

  int rise8 = 0, vcyc8 = 0, str8 = 0, par8 = 0;
  int stp8 = 0, ovr8 = 0, brk8 = 0, sb8 = 0;
  int rise7 = 0, par7 = 0, stp7 = 0, oth7 = 0;
  logic vq8 = 1'b0, vq7 = 1'b0;
  logic [7:0] last8 = '0;
  logic [6:0] last7 = '0;

  always @(negedge clk) begin
    vq8 <= vld8;
    if (vld8 && !vq8) begin
      rise8 <= rise8 + 1;
      last8 <= P_DATA8;
    end
    if (vld8) vcyc8 <= vcyc8 + 1;
    if (str_e8) str8 <= str8 + 1;
    if (par_e8) par8 <= par8 + 1;
    if (stp_e8) stp8 <= stp8 + 1;
    if (ovr_e8) ovr8 <= ovr8 + 1;
    if (brk_d8) brk8 <= brk8 + 1;
    if (stp_e8 && brk_d8) sb8 <= sb8 + 1;
    vq7 <= vld7;
    if (vld7 && !vq7) begin
      rise7 <= rise7 + 1;
      last7 <= P_DATA7;
    end
    if (par_e7) par7 <= par7 + 1;
    if (stp_e7) stp7 <= stp7 + 1;
    if (str_e7 || ovr_e7 || brk_d7) oth7 <= oth7 + 1;
  end

  function automatic int errs8();
    return str8 + par8 + stp8 + ovr8 + brk8;
  endfunction

  task automatic bit8(input logic v, input int p, input int fl);
    for (int k = 0; k < p; k++) begin
      rx8 = (k == fl) ? ~v : v;
      @(negedge clk);
    end
    rx8 = v;
  endtask

  task automatic send8(
    input logic [7:0] d, input int p,
    input logic pbit_en, input logic pbit,
    input int nstop, input logic sv,
    input int fbit, input int foff
  );
    bit8(1'b0, p, -1);
    for (int i = 0; i < 8; i++)
      bit8(d[i], p, (i == fbit) ? foff : -1);
    if (pbit_en) bit8(pbit, p, -1);
    for (int i = 0; i < nstop; i++) bit8(sv, p, -1);
    rx8 = 1'b1;
  endtask

  task automatic bit7(input logic v, input int p);
    rx7 = v;
    repeat (p) @(negedge clk);
  endtask

  task automatic send7(
    input logic [6:0] d, input int p,
    input logic pbit, input int nstop
  );
    bit7(1'b0, p);
    for (int i = 0; i < 7; i++) bit7(d[i], p);
    bit7(pbit, p);
    for (int i = 0; i < nstop; i++) bit7(1'b1, p);
    rx7 = 1'b1;
  endtask

  task automatic idle(input int n);
    rx8 = 1'b1;
    rx7 = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx8 = 1'b1; rx7 = 1'b1;
    pen8 = 0; ptyp8 = 0; stop2_8 = 0; ps8 = 6'd16; rdy8 = 1;
    pen7 = 1; ptyp7 = 0; stop2_7 = 1; ps7 = 6'd8; rdy7 = 1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({P_DATA8, vld8, str_e8, par_e8, stp_e8, ovr_e8, brk_d8}
        !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_out8: got %h want 0",
               {P_DATA8, vld8, str_e8, par_e8, stp_e8, ovr_e8, brk_d8});
    end
    rst_n = 1'b1;
    idle(8);
    n_chk++;
    if ({P_DATA7, vld7} !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_out7: got %h want 0", {P_DATA7, vld7});
    end
  endtask

  task automatic test_basic;
    int r, v, e;
    r = rise8; v = vcyc8; e = errs8();
    send8(8'hA5, 16, 0, 0, 1, 1, -1, 0);
    idle(20);
    n_chk++;
    if (last8 !== 8'hA5) begin
      n_fail++;
      $display("FAIL basic_data: got %h want a5", last8);
    end
    n_chk++;
    if (vcyc8 - v !== 1) begin
      n_fail++;
      $display("FAIL basic_vld_cycles: got %0d want 1", vcyc8 - v);
    end
    n_chk++;
    if (rise8 - r !== 1 || errs8() - e !== 0) begin
      n_fail++;
      $display("FAIL basic_count: rise %0d err %0d want 1 0",
               rise8 - r, errs8() - e);
    end
  endtask

  task automatic test_parity;
    int r, p, s, o;
    r = rise7; p = par7; s = stp7; o = oth7;
    send7(7'h3C, 8, 1'b0, 2);
    idle(10);
    n_chk++;
    if (rise7 - r !== 1 || last7 !== 7'h3C) begin
      n_fail++;
      $display("FAIL par_even_good: rise %0d data %h want 1 3c",
               rise7 - r, last7);
    end
    r = rise7;
    send7(7'h3C, 8, 1'b1, 2);
    idle(10);
    n_chk++;
    if (par7 - p !== 1) begin
      n_fail++;
      $display("FAIL par_err: got %0d want 1", par7 - p);
    end
    n_chk++;
    if (rise7 - r !== 0 || vld7 !== 1'b0) begin
      n_fail++;
      $display("FAIL par_no_vld: rise %0d vld %b want 0 0",
               rise7 - r, vld7);
    end
    ptyp7 = 1'b1;
    r = rise7;
    send7(7'h2A, 8, 1'b0, 2);
    idle(10);
    n_chk++;
    if (rise7 - r !== 1 || last7 !== 7'h2A) begin
      n_fail++;
      $display("FAIL par_odd_good: rise %0d data %h want 1 2a",
               rise7 - r, last7);
    end
    n_chk++;
    if (par7 - p !== 1 || stp7 - s !== 0 || oth7 - o !== 0) begin
      n_fail++;
      $display("FAIL par_other_err: par %0d stp %0d oth %0d want 1 0 0",
               par7 - p, stp7 - s, oth7 - o);
    end
    ptyp7 = 1'b0;
  endtask

  task automatic test_glitch;
    int r, s;
    r = rise8; s = str8;
    rx8 = 1'b0;
    repeat (2) @(negedge clk);
    idle(30);
    n_chk++;
    if (str8 - s !== 1 || rise8 - r !== 0) begin
      n_fail++;
      $display("FAIL glitch_str: str %0d rise %0d want 1 0",
               str8 - s, rise8 - r);
    end
    send8(8'h55, 16, 0, 0, 1, 1, -1, 0);
    idle(20);
    n_chk++;
    if (rise8 - r !== 1 || last8 !== 8'h55) begin
      n_fail++;
      $display("FAIL glitch_next: rise %0d data %h want 1 55",
               rise8 - r, last8);
    end
  endtask

  task automatic test_overrun;
    int r, o;
    r = rise8; o = ovr8;
    rdy8 = 1'b0;
    send8(8'h11, 16, 0, 0, 1, 1, -1, 0);
    send8(8'h22, 16, 0, 0, 1, 1, -1, 0);
    idle(10);
    n_chk++;
    if (P_DATA8 !== 8'h11 || vld8 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_hold: data %h vld %b want 11 1",
               P_DATA8, vld8);
    end
    n_chk++;
    if (ovr8 - o !== 1 || rise8 - r !== 1) begin
      n_fail++;
      $display("FAIL ovr_count: ovr %0d rise %0d want 1 1",
               ovr8 - o, rise8 - r);
    end
    rdy8 = 1'b1;
    @(negedge clk);
    n_chk++;
    if (vld8 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_release: vld %b want 0", vld8);
    end
  endtask

  task automatic test_break;
    int r, s, b, sb, e;
    r = rise8; s = stp8; b = brk8; sb = sb8;
    send8(8'h00, 16, 0, 0, 1, 0, -1, 0);
    idle(40);
    n_chk++;
    if (stp8 - s !== 1 || brk8 - b !== 1 || sb8 - sb !== 1) begin
      n_fail++;
      $display("FAIL break: stp %0d brk %0d both %0d want 1 1 1",
               stp8 - s, brk8 - b, sb8 - sb);
    end
    n_chk++;
    if (rise8 - r !== 0) begin
      n_fail++;
      $display("FAIL break_no_vld: rise %0d want 0", rise8 - r);
    end
    r = rise8; e = errs8();
    send8(8'h96, 16, 0, 0, 1, 1, 3, 10);
    idle(20);
    n_chk++;
    if (rise8 - r !== 1 || last8 !== 8'h96 || errs8() - e !== 0) begin
      n_fail++;
      $display("FAIL majority: rise %0d data %h err %0d want 1 96 0",
               rise8 - r, last8, errs8() - e);
    end
  endtask

  task automatic test_latch;
    int r, e;
    r = rise8; e = errs8();
    fork
      send8(8'h3A, 16, 0, 0, 1, 1, -1, 0);
      begin
        repeat (40) @(negedge clk);
        pen8 = 1'b1; ps8 = 6'd8; stop2_8 = 1'b1;
      end
    join
    idle(20);
    n_chk++;
    if (rise8 - r !== 1 || last8 !== 8'h3A || errs8() - e !== 0) begin
      n_fail++;
      $display("FAIL latch: rise %0d data %h err %0d want 1 3a 0",
               rise8 - r, last8, errs8() - e);
    end
    pen8 = 1'b0; ps8 = 6'd16; stop2_8 = 1'b0;
  endtask

  task automatic test_reset_mid;
    int r, e;
    logic [7:0] d;
    rdy8 = 1'b0;
    send8(8'h77, 16, 0, 0, 1, 1, -1, 0);
    idle(10);
    d = 8'hE3;
    bit8(1'b0, 16, -1);
    for (int i = 0; i < 4; i++) bit8(d[i], 16, -1);
    rx8 = d[4];
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({P_DATA8, vld8} !== 9'h0 || {P_DATA7, vld7} !== 8'h0) begin
      n_fail++;
      $display("FAIL rst_async: got %h %h want 0 0",
               {P_DATA8, vld8}, {P_DATA7, vld7});
    end
    @(negedge clk);
    rx8 = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({str_e8, par_e8, stp_e8, ovr_e8, brk_d8, vld8} !== 6'h0) begin
      n_fail++;
      $display("FAIL rst_hold: got %h want 0",
               {str_e8, par_e8, stp_e8, ovr_e8, brk_d8, vld8});
    end
    rst_n = 1'b1;
    rdy8 = 1'b1;
    idle(10);
    r = rise8; e = errs8();
    send8(8'h0F, 16, 0, 0, 1, 1, -1, 0);
    idle(20);
    n_chk++;
    if (rise8 - r !== 1 || last8 !== 8'h0F || errs8() - e !== 0) begin
      n_fail++;
      $display("FAIL rst_resume: rise %0d data %h err %0d want 1 0f 0",
               rise8 - r, last8, errs8() - e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_overrun();
    test_break();
    test_latch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
